vga_ctrl: RTL and testbench
===========================

Name: vga_ctrl

Overview:
VGA timing generator for 640x480@60 Hz, running in the vga_clk domain.
- Drives hsync/vsync and the pixel-coordinate request (pix_x, pix_y) to the pixel generator.
- Takes the generator's registered pix_data back and gates it onto the rgb output during the active window.
- Sits between the pixel generator and the board's VGA DAC pins; the top level is vga_ctrl plus the pixel generator.

Parameters:
H_SYNC, 96, hsync pulse width in clocks
H_BACK, 48, horizontal back porch (includes left border)
H_VALID, 640, active pixels per line
H_FRONT, 16, horizontal front porch (includes right border)
V_SYNC, 2, vsync pulse width in lines
V_BACK, 33, vertical back porch
V_VALID, 480, active lines per frame
V_FRONT, 10, vertical front porch
- H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525).
- Both totals must be ≤1024.

Ports:
vga_clk  in  1  pixel clock, 25 MHz
sys_rst_n  in  1  asynchronous active-low reset
pix_data  in  16  RGB565 from pixel generator; registered there, 1-clock latency after pix_x/pix_y
pix_x  out  10  requested column, 0..H_VALID-1, 10'h3FF when no request
pix_y  out  10  requested row, 0..V_VALID-1, 10'h3FF when no request
hsync  out  1  horizontal sync, active-high
vsync  out  1  vertical sync, active-high
rgb_valid  out  1  high while the active display window is on the wire
rgb  out  16  RGB565 to DAC
frame_cnt  out  16  (only with VGA_FRAME_CNT_EN) completed-frame count
frame_start  out  1  (only with VGA_FRAME_CNT_EN) 1-clock pulse at the first clock of a new frame

Behaviour:
Counters:
- cnt_h (10b): registered, async clear to 0, increments every clock, wraps from H_TOTAL-1 to 0.
- cnt_v (10b): registered, async clear to 0, increments only when cnt_h==H_TOTAL-1, wraps from V_TOTAL-1 to 0 on that same clock.

Syncs (combinational from the counters):
- hsync = (cnt_h ≤ H_SYNC-1).
- vsync = (cnt_v ≤ V_SYNC-1).

Display window:
- HS = H_SYNC+H_BACK (144). VS = V_SYNC+V_BACK (35).
- rgb_valid = HS ≤ cnt_h < HS+H_VALID, and VS ≤ cnt_v < VS+V_VALID.

Pixel request:
- pix_data_req is the same window as rgb_valid but shifted one clock earlier horizontally: HS-1 ≤ cnt_h < HS+H_VALID-1, same vertical range.
- This compensates for the pixel generator's 1-clock register.
- pix_x = pix_data_req ? cnt_h-(HS-1) : 10'h3FF.
- pix_y = pix_data_req ? cnt_v-VS : 10'h3FF.
- All subtraction is 10-bit unsigned and only evaluated inside the window, so there is no underflow.

RGB output:
- rgb = rgb_valid ? pix_data : 16'h0000.
- Blanking is always black, regardless of pix_data.

Reset:
- Applies immediately and asynchronously, mid-line or mid-frame.
- Values while sys_rst_n=0 (counters at 0,0): hsync=1, vsync=1, rgb_valid=0, rgb=0, pix_x=pix_y=10'h3FF.
- After release, the first clock edge advances cnt_h to 1.
- The first full frame starts at reset release; no partial-frame recovery is required.

Boundaries:
- Last active pixel of a line: cnt_h=783, pix_x invalid (3FF), rgb_valid=1.
- Line wrap: cnt_h 799→0 with cnt_v incremented on the same edge.
- Frame wrap: (799,524)→(0,0).
- Line 514 (last active line) still issues requests; line 515 does not.

Optional Feature:
Macro VGA_FRAME_CNT_EN. When defined:
- frame_cnt (16b) registered, reset 0; increments on the clock where cnt_h==H_TOTAL-1 and cnt_v==V_TOTAL-1; wraps FFFF→0.
- frame_start registered, reset 0; high for exactly one clock when the counters read (0,0) after a frame wrap. It is not asserted at the first (0,0) after reset.

When undefined:
- Both ports and their logic are absent.
- All other behaviour is identical.

Test Plan:
- Reset held 10 clocks mid-frame, then released → during reset hsync=1, vsync=1, rgb_valid=0, rgb=0, pix_x=pix_y=3FF; one clock after release cnt_h=1.
- Line timing: count clocks over one line → hsync high for clocks 0..95 of the line; line period exactly 800; vsync high for lines 0..1; frame period 420000 clocks.
- Request/data alignment: model the pixel generator as pix_data <= {6'h0,pix_x} registered on vga_clk → at (cnt_h=143, cnt_v=35) pix_x=0, pix_y=0, rgb_valid=0; at cnt_h=144 rgb=16'h0000 with rgb_valid=1; at cnt_h=783 rgb=16'h027F; at cnt_h=784 rgb_valid=0, rgb=0.
- Blanking forced black: drive pix_data=16'hF800 constant → rgb=F800 only inside the window; rgb=0 at cnt_h=100 and on cnt_v=20.
- Window edges: pix_y=479 on line 514; pix_y=3FF on line 515; pix_x=639 at cnt_h=782 and 3FF at cnt_h=783.
- VGA_FRAME_CNT_EN: run 3 frames → frame_start pulses exactly 3 times, each 1 clock wide, none directly after reset; frame_cnt=3 at end. With frame_cnt preloaded to FFFF via force, one more frame → frame_cnt=0.

Source files
------------

// File: rtl/vga_ctrl_if.sv
// Signal bundle between the VGA timing generator, its pixel generator and the DAC pins.
// frame_cnt / frame_start exist only when VGA_FRAME_CNT_EN is defined.
interface vga_ctrl_if;
    logic [15:0] pix_data;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        hsync;
    logic        vsync;
    logic        rgb_valid;
    logic [15:0] rgb;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic        frame_start;

    modport master (
        input  pix_data,
        output pix_x, pix_y, hsync, vsync, rgb_valid, rgb, frame_cnt, frame_start
    );
    modport slave (
        output pix_data,
        input  pix_x, pix_y, hsync, vsync, rgb_valid, rgb, frame_cnt, frame_start
    );
`else
    modport master (
        input  pix_data,
        output pix_x, pix_y, hsync, vsync, rgb_valid, rgb
    );
    modport slave (
        output pix_data,
        input  pix_x, pix_y, hsync, vsync, rgb_valid, rgb
    );
`endif
endinterface

// File: rtl/vga_ctrl.sv
// 640x480@60 VGA timing generator: sync pulses, pixel requests and gated RGB output.
// Optional completed-frame counter and frame-start pulse enabled by VGA_FRAME_CNT_EN.
module vga_ctrl #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_VALID = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_VALID = 480,
    parameter int V_FRONT = 10
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    vga_ctrl_if.master vga
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int HS      = H_SYNC + H_BACK;
    localparam int VS      = V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_BEG  = 10'(HS);
    localparam logic [9:0] H_ACT_END  = 10'(HS + H_VALID);
    localparam logic [9:0] H_REQ_BEG  = 10'(HS - 1);
    localparam logic [9:0] H_REQ_END  = 10'(HS + H_VALID - 1);
    localparam logic [9:0] V_ACT_BEG  = 10'(VS);
    localparam logic [9:0] V_ACT_END  = 10'(VS + V_VALID);
    localparam logic [9:0] NO_REQ     = 10'h3FF;

    logic [9:0] cnt_h;
    logic [9:0] cnt_v;
    logic       line_end;
    logic       frame_end;
    logic       win_v;
    logic       act_h;
    logic       req_h;
    logic       rgb_valid;
    logic       pix_data_req;

    assign line_end  = (cnt_h == H_LAST);
    assign frame_end = line_end && (cnt_v == V_LAST);

    // Stage p0: raster position counters
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h <= '0;
        end else if (line_end) begin
            cnt_h <= '0;
        end else begin
            cnt_h <= cnt_h + 10'd1;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_v <= '0;
        end else if (line_end) begin
            if (cnt_v == V_LAST) begin
                cnt_v <= '0;
            end else begin
                cnt_v <= cnt_v + 10'd1;
            end
        end
    end

    // The request window leads the display window by one clock to cover the
    // pixel generator's output register.
    assign win_v        = (cnt_v >= V_ACT_BEG) && (cnt_v < V_ACT_END);
    assign act_h        = (cnt_h >= H_ACT_BEG) && (cnt_h < H_ACT_END);
    assign req_h        = (cnt_h >= H_REQ_BEG) && (cnt_h < H_REQ_END);
    assign rgb_valid    = act_h && win_v;
    assign pix_data_req = req_h && win_v;

    assign vga.hsync     = (cnt_h < H_SYNC_END);
    assign vga.vsync     = (cnt_v < V_SYNC_END);
    assign vga.rgb_valid = rgb_valid;
    assign vga.pix_x     = pix_data_req ? (cnt_h - H_REQ_BEG) : NO_REQ;
    assign vga.pix_y     = pix_data_req ? (cnt_v - V_ACT_BEG) : NO_REQ;
    assign vga.rgb       = rgb_valid ? vga.pix_data : 16'h0000;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_p0;
    logic        frame_start_p0;

    // Stage p0: frame bookkeeping; frame_start lands on the (0,0) clock after a wrap
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_cnt_p0   <= '0;
            frame_start_p0 <= 1'b0;
        end else begin
            frame_start_p0 <= frame_end;
            if (frame_end) begin
                frame_cnt_p0 <= frame_cnt_p0 + 16'd1;
            end
        end
    end

    assign vga.frame_cnt   = frame_cnt_p0;
    assign vga.frame_start = frame_start_p0;
`endif

endmodule

// File: tb/tb_vga_ctrl.sv
// Directed-plus-random bench for vga_ctrl against a raster-position reference model.
`timescale 1ns/1ps
module tb_vga_ctrl;
    localparam int H_TOT = 800;
    localparam int V_TOT = 525;
    localparam int FRAME = H_TOT * V_TOT;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   mode  = 2;

    vga_ctrl_if vif();

    vga_ctrl dut (
        .vga_clk   (clk),
        .sys_rst_n (rst_n),
        .vga       (vif)
    );

    always #20 clk = ~clk;

    // Pixel generator: registered, one clock behind the request
    always @(posedge clk) begin
        case (mode)
            0:       vif.pix_data <= {6'h0, vif.pix_x};
            1:       vif.pix_data <= 16'hF800;
            default: vif.pix_data <= 16'($urandom);
        endcase
    end

    int n_cmp  = 0;
    int n_err  = 0;
    int t      = 0;
    int frames = 0;
    bit wrapped = 1'b0;
    int pulses = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic check_all();
        int h;
        int v;
        bit wv;
        bit rv;
        bit rq;
        logic [15:0] er;
        h  = t % H_TOT;
        v  = t / H_TOT;
        wv = (v >= 35) && (v < 515);
        rv = wv && (h >= 144) && (h < 784);
        rq = wv && (h >= 143) && (h < 783);
        case (mode)
            0:       er = rv ? 16'(h - 144) : 16'h0000;
            1:       er = rv ? 16'hF800 : 16'h0000;
            default: er = rv ? vif.pix_data : 16'h0000;
        endcase
        chk("hsync", 32'(vif.hsync), 32'(h < 96));
        chk("vsync", 32'(vif.vsync), 32'(v < 2));
        chk("rgb_valid", 32'(vif.rgb_valid), 32'(rv));
        chk("rgb", 32'(vif.rgb), 32'(er));
        chk("pix_x", 32'(vif.pix_x), rq ? 32'(h - 143) : 32'h3FF);
        chk("pix_y", 32'(vif.pix_y), rq ? 32'(v - 35) : 32'h3FF);
`ifdef VGA_FRAME_CNT_EN
        chk("frame_start", 32'(vif.frame_start), 32'(wrapped && t == 0));
        chk("frame_cnt", 32'(vif.frame_cnt), 32'(frames & 16'hFFFF));
        if (vif.frame_start === 1'b1) pulses++;
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) begin
            t++;
            wrapped = 1'b0;
            if (t == FRAME) begin
                t = 0;
                wrapped = 1'b1;
                frames++;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic run_to(input int h, input int v, input string tag);
        int n = 0;
        while (!((t % H_TOT) == h && (t / H_TOT) == v) && n < 3000) begin
            cyc();
            n++;
        end
        if (n >= 3000) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_timeout: observed=%0d expected=%0d", tag, t, v * H_TOT + h);
        end
    endtask

    // Moves the line counter; called at a negedge so the edge logic is undisturbed
    task automatic jump_v(input int v);
        force dut.cnt_v = 10'(v);
        t = v * H_TOT + (t % H_TOT);
        #1;
        release dut.cnt_v;
        #1;
        check_all();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int v_hi;
        int h_lo;
        int h_hi;

        // Power-on reset
        #5 rst_n = 1'b0;
        #1 check_all();
        repeat (5) cyc();
        rst_n = 1'b1;

        // Random pixel data over a random stretch of the top blanking area
        repeat ($urandom_range(1500, 3000)) cyc();

        // Asynchronous reset mid-line, held 10 clocks
        @(posedge clk);
        #3 rst_n = 1'b0;
        t = 0; frames = 0; wrapped = 1'b0; pulses = 0;
        #1 check_all();
        repeat (10) cyc();
        rst_n = 1'b1;
        cyc();
        chk("cnt_h_after_release", 32'(dut.cnt_h), 32'd1);

        // vsync high for lines 0..1 (1600 clocks including t=0)
        v_hi = 2;
        while (v_hi < 5000) begin
            cyc();
            if (vif.vsync === 1'b1) v_hi++;
            else break;
        end
        chk("vsync_high_clocks", 32'(v_hi), 32'd1600);

        // hsync: low part and high part of one full line
        h_lo = 0;
        h_hi = 0;
        while (vif.hsync === 1'b1 && h_lo < 2000) begin cyc(); h_lo++; end
        h_lo = 0;
        while (vif.hsync === 1'b0 && h_lo < 2000) begin cyc(); h_lo++; end
        while (vif.hsync === 1'b1 && h_hi < 2000) begin cyc(); h_hi++; end
        chk("hsync_high_clocks", 32'(h_hi), 32'd96);
        chk("line_period", 32'(h_lo + h_hi), 32'd800);

        // Request/data alignment with an echoing pixel generator
        mode = 0;
        jump_v(34);
        run_to(143, 35, "first_req");
        chk("first_req_pix_x", 32'(vif.pix_x), 32'h0);
        chk("first_req_pix_y", 32'(vif.pix_y), 32'h0);
        chk("first_req_rgb_valid", 32'(vif.rgb_valid), 32'h0);
        cyc();
        chk("first_pix_rgb", 32'(vif.rgb), 32'h0000);
        chk("first_pix_valid", 32'(vif.rgb_valid), 32'h1);
        run_to(782, 35, "last_req");
        chk("last_req_pix_x", 32'(vif.pix_x), 32'd639);
        cyc();
        chk("last_pix_rgb", 32'(vif.rgb), 32'h027F);
        chk("last_pix_pix_x", 32'(vif.pix_x), 32'h3FF);
        chk("last_pix_valid", 32'(vif.rgb_valid), 32'h1);
        cyc();
        chk("after_line_valid", 32'(vif.rgb_valid), 32'h0);
        chk("after_line_rgb", 32'(vif.rgb), 32'h0);

        // Blanking stays black with a constant red generator
        run_to(0, 36, "line36");
        mode = 1;
        run_to(100, 36, "hblank");
        chk("hblank_rgb_black", 32'(vif.rgb), 32'h0);
        run_to(400, 36, "red_pix");
        chk("window_rgb_red", 32'(vif.rgb), 32'hF800);
        jump_v(20);
        chk("vblank_rgb_black", 32'(vif.rgb), 32'h0);
        repeat (H_TOT) cyc();

        // Bottom edge of the window with random pixel data
        mode = 2;
        jump_v(513);
        run_to(143, 514, "line514");
        chk("line514_pix_y", 32'(vif.pix_y), 32'd479);
        run_to(143, 515, "line515");
        chk("line515_pix_y", 32'(vif.pix_y), 32'h3FF);

        // Frame wrap (799,524) -> (0,0)
        jump_v(524);
        run_to(799, 524, "frame_end");
        cyc();
        chk("wrap_cnt_h", 32'(dut.cnt_h), 32'h0);
        chk("wrap_cnt_v", 32'(dut.cnt_v), 32'h0);
        chk("wrap_vsync", 32'(vif.vsync), 32'h1);

`ifdef VGA_FRAME_CNT_EN
        repeat (2) begin
            cyc();
            jump_v(524);
            run_to(0, 0, "next_frame");
        end
        chk("frame_cnt_after_3", 32'(vif.frame_cnt), 32'd3);
        chk("frame_start_pulses", 32'(pulses), 32'd3);
        force dut.frame_cnt_p0 = 16'hFFFF;
        frames = 16'hFFFF;
        #1;
        release dut.frame_cnt_p0;
        cyc();
        jump_v(524);
        run_to(0, 0, "rollover_frame");
        chk("frame_cnt_rollover", 32'(vif.frame_cnt), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
